pool_window_ctrl: RTL and testbench
===================================

POOL_WINDOW_CTRL -- requirements
Module: pool_window_ctrl

Interface
REQ-001 Parameter IW, default 4: input feature-map width in pixels; even, at least 2.
REQ-002 Parameter IH, default 4: input feature-map height in pixels; even, at least 2.
REQ-003 Parameter POOL_LAT, default 1: fixed latency of the downstream 2x2 max-pool datapath, in cycles.
REQ-004 Ports clk (in, 1, rising-edge clock) and reset_n (in, 1, reset) SHALL be the only clock and reset; reset is asynchronous and active-low.
REQ-005 i_start  in  1  frame start request; sampled only in IDLE.
REQ-006 i_in_valid  in  1  input pixel valid.
REQ-007 i_in_fmap  in  LANES*W_BW  one pixel for all lanes (LANES = CO*CI); lane k is at bits [k*W_BW +: W_BW].
REQ-008 o_in_ready  out  1  controller accepts a pixel this cycle.
REQ-009 o_win_valid  out  1  window valid to the pool datapath.
REQ-010 o_win_fmap  out  LANES*4*W_BW  2x2 windows; slot (k*4+j) holds lane k, with j = 0 top-left, 1 top-right, 2 bottom-left, 3 bottom-right.
REQ-011 o_busy  out  1  high in RUN and DRAIN.
REQ-012 o_done  out  1  one-cycle frame-complete pulse.

Function
REQ-013 The FSM SHALL have four states: IDLE, RUN, DRAIN and DONE.
- IDLE to RUN: on i_start.
- RUN to DRAIN: on acceptance of pixel (IH-1, IW-1).
- DRAIN to DONE: after POOL_LAT cycles.
- DONE to IDLE: unconditionally, after one cycle.
REQ-014 o_in_ready SHALL equal 1 only in RUN; a pixel is accepted when i_in_valid and o_in_ready are both high.
REQ-015 Pixels SHALL arrive in raster order, with column counter col (0..IW-1) and row counter row (0..IH-1). Each counter advances only on acceptance. col wraps to 0 and row increments when col = IW-1.
REQ-016 A line buffer of IW/2 entries, each 2*LANES*W_BW wide, SHALL store the horizontal pixel pairs of each even row.
- Write entry col/2 when an odd column is accepted.
- An even-column pixel is held in a one-entry register.
REQ-017 On acceptance of a pixel with both row and col odd, o_win_valid SHALL assert in the next cycle for exactly one cycle. That cycle's window is: the stored pair from entry col/2 (TL, TR), the held even-column pixel (BL), and the accepted pixel (BR).
REQ-018 o_win_fmap SHALL hold its last value when o_win_valid is low; consumers must qualify it with o_win_valid.
REQ-019 Exactly (IW/2)*(IH/2) windows SHALL be issued per frame, with no skipped or duplicated window.
REQ-020 o_done SHALL pulse in the DONE cycle, which is POOL_LAT+1 cycles after the last o_win_valid cycle, aligned with the last pooled result leaving the datapath plus one cycle.
REQ-021 i_start outside IDLE SHALL be ignored. i_in_valid outside RUN SHALL be ignored, with no state or counter change.
REQ-022 Gaps in i_in_valid SHALL stall the counters only; window contents and ordering are unaffected.
REQ-023 Counter widths SHALL be clog2(IW) and clog2(IH) bits. No arithmetic is performed on pixel data; it passes bit-exact.
REQ-024 If i_start and the final pixel occur in the same cycle (an impossible state combination), the FSM transition rules of REQ-013 SHALL govern.

Reset
REQ-025 While reset_n is low, all of the following SHALL be cleared asynchronously: state = IDLE, col = 0, row = 0, o_win_valid = 0, o_win_fmap = 0, o_done = 0, o_busy = 0, o_in_ready = 0, held-pixel register = 0.
REQ-026 Line-buffer contents need not be cleared, since they are always written before being read.
REQ-027 Reset asserted mid-frame SHALL abort the frame without an o_done pulse. After release, the block SHALL wait for a new i_start.

Structure
REQ-028 CO, CI, LANES and W_BW SHALL come from the shared CNN defines header; window slot ordering (REQ-010) SHALL be defined there as named constants.
REQ-029 The line buffer SHALL be one sub-module, pool_line_buf: a single write port and a single read port, with IW/2 depth and a synchronous write.

Verification
REQ-030 Scenario 1. Setup: IW=4, IH=4, LANES=1, W_BW=8, continuous valid. Stimulus: pixels 0..15 in raster order. Required: 4 windows {0,1,4,5}, {2,3,6,7}, {8,9,12,13}, {10,11,14,15} in that order; o_done 2 cycles after the 4th window.
REQ-031 Scenario 2. Stimulus: same frame with i_in_valid toggling 1,0,1,0. Required: identical windows, each 1 cycle after its BR acceptance.
REQ-032 Scenario 3. Stimulus: i_in_valid high in IDLE with no i_start. Required: o_in_ready = 0, no o_win_valid, counters stay 0.
REQ-033 Scenario 4. Stimulus: reset_n low after pixel 9 is accepted, then released, then i_start and a fresh frame of pixels 100..115. Required: no o_done for the aborted frame; windows {100,101,104,105} onward.
REQ-034 Scenario 5. Stimulus: i_start pulsed during RUN. Required: no effect; exactly 4 windows and one o_done.
REQ-035 Scenario 6. Setup: LANES=2. Stimulus: lane1 = lane0 + 64. Required: slot 4..7 of each window equals slots 0..3 plus 64.

Source files
------------

// File: rtl/pool_window_ctrl_pkg.sv
// Shared CNN lane geometry and 2x2 window slot ordering for the pooling front end.
// Slot (lane*4 + pos) of a window holds lane 'lane' at position 'pos'.
package pool_window_ctrl_pkg;

    localparam int CO    = 1;
    localparam int CI    = 2;
    localparam int LANES = CO * CI;
    localparam int W_BW  = 8;

    localparam int SLOT_TL = 0;
    localparam int SLOT_TR = 1;
    localparam int SLOT_BL = 2;
    localparam int SLOT_BR = 3;
    localparam int SLOTS   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int slot_lsb(input int lane, input int pos);
        return (lane * SLOTS + pos) * W_BW;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer holding the horizontal pixel pairs of one even row.
// Write lands on the next clock edge; read is combinational. No backpressure.
module pool_line_buf #(
    parameter int DEPTH = 2,
    parameter int AW    = 1,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          wr_vld,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/pool_window_ctrl.sv
// Raster pixel stream to 2x2 max-pool windows; window issued 1 cycle after its
// bottom-right pixel is accepted. Accepts only in RUN (o_in_ready), stalls on gaps.
module pool_window_ctrl
    import pool_window_ctrl_pkg::*;
#(
    parameter int IW       = 4,
    parameter int IH       = 4,
    parameter int POOL_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      i_start,
    input  logic                      i_in_valid,
    input  logic [LANES*W_BW-1:0]     i_in_fmap,
    output logic                      o_in_ready,
    output logic                      o_win_valid,
    output logic [LANES*4*W_BW-1:0]   o_win_fmap,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int PIX_W    = LANES * W_BW;
    localparam int WIN_W    = SLOTS * PIX_W;
    localparam int CW       = $clog2(IW);
    localparam int RW       = $clog2(IH);
    localparam int LB_DEPTH = IW / 2;
    localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam int DCW      = $clog2(POOL_LAT + 1) + 1;

    state_e           state_q;
    logic [CW-1:0]    col_q;
    logic [RW-1:0]    row_q;
    logic [PIX_W-1:0] hold_q;
    logic [DCW-1:0]   drain_cnt_q;
    logic             in_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             win_vld_q;
    logic [WIN_W-1:0] win_fmap_q;

    logic             accept;
    logic             col_last;
    logic             row_last;
    logic             lb_wr_vld;
    logic [AW-1:0]    lb_addr;
    logic [2*PIX_W-1:0] lb_rd_dat;
    logic [WIN_W-1:0] win_asm;

    assign accept    = i_in_valid & in_ready_q;
    assign col_last  = (col_q == CW'(IW - 1));
    assign row_last  = (row_q == RW'(IH - 1));
    assign lb_addr   = AW'(col_q >> 1);
    // Even rows park the completed {right, left} pair; odd rows only read it back.
    assign lb_wr_vld = accept & ~row_q[0] & col_q[0];

    pool_line_buf #(
        .DEPTH (LB_DEPTH),
        .AW    (AW),
        .DW    (2 * PIX_W)
    ) u_line_buf (
        .clk     (clk),
        .wr_vld  (lb_wr_vld),
        .wr_addr (lb_addr),
        .wr_dat  ({i_in_fmap, hold_q}),
        .rd_addr (lb_addr),
        .rd_dat  (lb_rd_dat)
    );

    always_comb begin
        win_asm = '0;
        for (int k = 0; k < LANES; k++) begin
            win_asm[slot_lsb(k, SLOT_TL) +: W_BW] = lb_rd_dat[k*W_BW +: W_BW];
            win_asm[slot_lsb(k, SLOT_TR) +: W_BW] = lb_rd_dat[PIX_W + k*W_BW +: W_BW];
            win_asm[slot_lsb(k, SLOT_BL) +: W_BW] = hold_q[k*W_BW +: W_BW];
            win_asm[slot_lsb(k, SLOT_BR) +: W_BW] = i_in_fmap[k*W_BW +: W_BW];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            drain_cnt_q <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            win_vld_q   <= 1'b0;
            win_fmap_q  <= '0;
        end else begin
            win_vld_q <= accept & row_q[0] & col_q[0];
            if (accept & row_q[0] & col_q[0]) begin
                win_fmap_q <= win_asm;
            end
            if (accept & ~col_q[0]) begin
                hold_q <= i_in_fmap;
            end

            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (i_start) begin
                        state_q    <= ST_RUN;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        col_q      <= '0;
                        row_q      <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (col_last) begin
                            col_q <= '0;
                            row_q <= row_last ? '0 : row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                        if (col_last && row_last) begin
                            state_q     <= ST_DRAIN;
                            in_ready_q  <= 1'b0;
                            drain_cnt_q <= '0;
                        end
                    end
                end
                // Counting starts with the last window cycle, so DONE lands
                // POOL_LAT+1 cycles after that window.
                ST_DRAIN: begin
                    if (drain_cnt_q == DCW'(POOL_LAT)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = in_ready_q;
    assign o_win_valid = win_vld_q;
    assign o_win_fmap  = win_fmap_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_pool_window_ctrl.sv
// Scoreboard bench for pool_window_ctrl: expected windows and done pulses are
// queued as pixels are accepted and compared when the DUT emits them.
module tb_pool_window_ctrl;
    import pool_window_ctrl_pkg::*;

    localparam int IW       = 4;
    localparam int IH       = 4;
    localparam int POOL_LAT = 1;
    localparam int PIX_W    = LANES * W_BW;
    localparam int WIN_W    = 4 * PIX_W;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               i_start;
    logic               i_in_valid;
    logic [PIX_W-1:0]   i_in_fmap;
    logic               o_in_ready;
    logic               o_win_valid;
    logic [WIN_W-1:0]   o_win_fmap;
    logic               o_busy;
    logic               o_done;

    pool_window_ctrl #(
        .IW       (IW),
        .IH       (IH),
        .POOL_LAT (POOL_LAT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_start     (i_start),
        .i_in_valid  (i_in_valid),
        .i_in_fmap   (i_in_fmap),
        .o_in_ready  (o_in_ready),
        .o_win_valid (o_win_valid),
        .o_win_fmap  (o_win_fmap),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    logic [WIN_W-1:0] exp_win_q [$];
    int               exp_wcyc_q [$];
    int               exp_done_q [$];
    int               done_seen = 0;
    logic [WIN_W-1:0] last_win = '0;
    logic [WIN_W-1:0] mon_w;
    int               mon_c;

    // Lane k carries the lane-0 value plus 64*k.
    function automatic logic [PIX_W-1:0] pix(input int v);
        logic [PIX_W-1:0] p;
        p = '0;
        for (int k = 0; k < LANES; k++) p[k*W_BW +: W_BW] = W_BW'(v + 64 * k);
        return p;
    endfunction

    function automatic logic [WIN_W-1:0] win_of(input int base, input int r, input int c);
        logic [WIN_W-1:0] w;
        int v [4];
        v[0] = base + (r - 1) * IW + c - 1;
        v[1] = base + (r - 1) * IW + c;
        v[2] = base + r * IW + c - 1;
        v[3] = base + r * IW + c;
        w = '0;
        for (int k = 0; k < LANES; k++)
            for (int j = 0; j < 4; j++)
                w[(k * 4 + j) * W_BW +: W_BW] = W_BW'(v[j] + 64 * k);
        return w;
    endfunction

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (o_win_valid) begin
                if (exp_win_q.size() == 0) begin
                    check_eq("win_unexp", o_win_valid, 1'b0);
                end else begin
                    mon_w = exp_win_q.pop_front();
                    mon_c = exp_wcyc_q.pop_front();
                    check_eq("win_dat", o_win_fmap, mon_w);
                    check_eq("win_cyc", cyc, mon_c);
                    last_win = mon_w;
                end
            end
            if (o_done) begin
                done_seen++;
                if (exp_done_q.size() == 0) check_eq("done_unexp", o_done, 1'b0);
                else check_eq("done_cyc", cyc, exp_done_q.pop_front());
            end
        end
    end

    task automatic run_frame(input int base, input bit gap, input int abort_at, input int start_at);
        int idx = 0;
        int budget = 0;
        bit tog = 1'b0;
        int r, c;
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check_eq("run_busy", o_busy, 1'b1);
        while (idx < IW * IH && budget < 200) begin
            i_in_valid = gap ? !tog : 1'b1;
            tog = !tog;
            i_in_fmap = pix(base + idx);
            i_start = (idx == start_at);
            if (i_in_valid && o_in_ready) begin
                r = idx / IW;
                c = idx % IW;
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    exp_win_q.push_back(win_of(base, r, c));
                    exp_wcyc_q.push_back(cyc + 1);
                    if (idx == IW * IH - 1) exp_done_q.push_back(cyc + 1 + POOL_LAT + 1);
                end
                if (idx == abort_at) begin
                    @(posedge clk);
                    #1;
                    reset_n = 1'b0;
                    i_in_valid = 1'b0;
                    i_start = 1'b0;
                    return;
                end
                idx++;
            end
            @(negedge clk);
            budget++;
        end
        i_in_valid = 1'b0;
        i_start = 1'b0;
        check_eq("feed_count", idx, IW * IH);
    endtask

    task automatic finish_frame();
        int budget = 0;
        while ((exp_win_q.size() + exp_done_q.size()) != 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        check_eq("drain_pending", exp_win_q.size() + exp_done_q.size(), 0);
        check_eq("idle_busy", o_busy, 1'b0);
        check_eq("idle_ready", o_in_ready, 1'b0);
        check_eq("fmap_hold", o_win_fmap, last_win);
    endtask

    int d0;

    initial begin
        reset_n = 1'b0;
        i_start = 1'b0;
        i_in_valid = 1'b0;
        i_in_fmap = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", o_in_ready, 1'b0);
        check_eq("rst_busy", o_busy, 1'b0);
        check_eq("rst_done", o_done, 1'b0);
        check_eq("rst_wvld", o_win_valid, 1'b0);
        check_eq("rst_fmap", o_win_fmap, '0);
        reset_n = 1'b1;
        @(negedge clk);

        // valid without start must be ignored
        i_in_valid = 1'b1;
        i_in_fmap = pix(77);
        repeat (4) begin
            @(negedge clk);
            check_eq("s3_ready", o_in_ready, 1'b0);
            check_eq("s3_busy", o_busy, 1'b0);
        end
        i_in_valid = 1'b0;

        d0 = done_seen;
        run_frame(0, 1'b0, -1, -1);
        finish_frame();
        check_eq("s1_done_cnt", done_seen - d0, 1);

        d0 = done_seen;
        run_frame(0, 1'b1, -1, -1);
        finish_frame();
        check_eq("s2_done_cnt", done_seen - d0, 1);

        d0 = done_seen;
        run_frame(0, 1'b0, 9, -1);
        repeat (2) @(negedge clk);
        check_eq("abort_busy", o_busy, 1'b0);
        check_eq("abort_ready", o_in_ready, 1'b0);
        check_eq("abort_wvld", o_win_valid, 1'b0);
        check_eq("abort_fmap", o_win_fmap, '0);
        check_eq("abort_pending", exp_win_q.size() + exp_done_q.size(), 0);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("abort_no_done", done_seen - d0, 0);
        check_eq("abort_wait_busy", o_busy, 1'b0);
        last_win = '0;
        run_frame(100, 1'b0, -1, -1);
        finish_frame();
        check_eq("s4_done_cnt", done_seen - d0, 1);

        d0 = done_seen;
        run_frame(0, 1'b0, -1, 6);
        finish_frame();
        repeat (4) @(negedge clk);
        check_eq("s5_done_cnt", done_seen - d0, 1);
        check_eq("s5_idle_busy", o_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
